// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: IR fields, ALU flag and memory handshakes in; datapath control buses out.
interface multi_cycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0] Op;
  logic [5:0] Funct;
  logic Zero;
  logic IMRdy;
  logic DMRdy;
  logic IRWr;
  logic PCWr;
  logic RFWr;
  logic DMWr;
  logic DMRd;
  logic [1:0] EXTOp;
  logic [1:0] NPCOp;
  logic [4:0] ALUOp;
  logic [1:0] RegDst;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic MemtoReg;
  logic Illegal;
  logic [CNT_W-1:0] RetireCnt;
  modport master (
    input  Op, Funct, Zero, IMRdy, DMRdy,
    output IRWr, PCWr, RFWr, DMWr, DMRd, EXTOp, NPCOp, ALUOp, RegDst, ALUSrcA, ALUSrcB, MemtoReg, Illegal, RetireCnt
  );
  modport slave (
    output Op, Funct, Zero, IMRdy, DMRdy,
    input  IRWr, PCWr, RFWr, DMWr, DMRd, EXTOp, NPCOp, ALUOp, RegDst, ALUSrcA, ALUSrcB, MemtoReg, Illegal, RetireCnt
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a shared-datapath MIPS core.
module multi_cycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  multi_cycle_ctrl_if.master bus
);
  localparam logic [1:0] NPC_PLUS4 = 2'd0, NPC_BRANCH = 2'd1, NPC_JUMP = 2'd2, NPC_JR = 2'd3;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGNED = 2'd1, EXT_HIGHPOS = 2'd2;
  localparam logic [4:0] ALU_NOP = 5'd0, ALU_ADD = 5'd1, ALU_OR = 5'd4, ALU_ADDU = 5'd7, ALU_SUBU = 5'd8;
  localparam logic [4:0] ALU_SLL = 5'd11, ALU_SRL = 5'd12, ALU_SRA = 5'd13, ALU_EQL = 5'd14;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic retire;
  logic r_t, addu, subu, sll, srl, sra, jr, ori, lui, lw, sw, beq, j, jal, shift, exec_cls;
  logic [1:0] alu_a, alu_b, alu_ext;
  logic [4:0] alu_op;
  assign r_t = bus.Op == 6'h00;
  assign addu = r_t && bus.Funct == 6'h21;
  assign subu = r_t && bus.Funct == 6'h23;
  assign sll = r_t && bus.Funct == 6'h00;
  assign srl = r_t && bus.Funct == 6'h02;
  assign sra = r_t && bus.Funct == 6'h03;
  assign jr = r_t && bus.Funct == 6'h08;
  assign ori = bus.Op == 6'h0d;
  assign lui = bus.Op == 6'h0f;
  assign lw = bus.Op == 6'h23;
  assign sw = bus.Op == 6'h2b;
  assign beq = bus.Op == 6'h04;
  assign j = bus.Op == 6'h02;
  assign jal = bus.Op == 6'h03;
  assign shift = sll | srl | sra;
  assign exec_cls = addu | subu | shift | ori | lui | lw | sw | beq;
  // EXEC operand/function selects, re-driven through MEM and WB
  assign alu_a = shift ? 2'd1 : 2'd0;
  assign alu_b = (shift | ori | lui | lw | sw) ? 2'd1 : 2'd0;
  assign alu_ext = lui ? EXT_HIGHPOS : (lw | sw) ? EXT_SIGNED : EXT_ZERO;
  assign alu_op = addu ? ALU_ADDU : subu ? ALU_SUBU : sll ? ALU_SLL : srl ? ALU_SRL : sra ? ALU_SRA :
                  ori ? ALU_OR : (lw | sw) ? ALU_ADD : beq ? ALU_EQL : ALU_NOP;
  assign bus.RetireCnt = cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  always_comb begin
    state_d = state_q;
    retire = 1'b0;
    bus.IRWr = 1'b0;
    bus.PCWr = 1'b0;
    bus.RFWr = 1'b0;
    bus.DMWr = 1'b0;
    bus.DMRd = 1'b0;
    bus.Illegal = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.NPCOp = NPC_PLUS4;
    bus.RegDst = 2'd0;
    bus.ALUSrcA = 2'd0;
    bus.ALUSrcB = 2'd0;
    bus.ALUOp = ALU_NOP;
    bus.EXTOp = EXT_ZERO;
    if (state_q inside {EXEC, MEM, WB}) begin
      bus.ALUSrcA = alu_a;
      bus.ALUSrcB = alu_b;
      bus.ALUOp = alu_op;
      bus.EXTOp = alu_ext;
    end
    case (state_q)
      FETCH: if (bus.IMRdy) begin
        bus.IRWr = 1'b1;
        bus.PCWr = 1'b1;
        state_d = DECODE;
      end
      DECODE: if (j | jal | jr) begin
        bus.PCWr = 1'b1;
        bus.NPCOp = jr ? NPC_JR : NPC_JUMP;
        bus.RFWr = jal;
        bus.RegDst = jal ? 2'd2 : 2'd0;
        bus.ALUSrcA = jal ? 2'd2 : 2'd0;
        bus.ALUSrcB = jal ? 2'd2 : 2'd0;
        bus.ALUOp = jal ? ALU_ADDU : ALU_NOP;
        state_d = FETCH;
        retire = 1'b1;
      end else if (exec_cls) begin
        state_d = EXEC;
      end else begin
        bus.Illegal = 1'b1;
        state_d = FETCH;
      end
      EXEC: if (beq) begin
        bus.NPCOp = NPC_BRANCH;
        bus.PCWr = bus.Zero;
        state_d = FETCH;
        retire = 1'b1;
      end else begin
        state_d = (lw | sw) ? MEM : WB;
      end
      MEM: begin
        bus.DMRd = lw;
        bus.DMWr = sw;
        if (bus.DMRdy) begin
          state_d = lw ? WB : FETCH;
          retire = sw;
        end
      end
      WB: begin
        bus.RFWr = 1'b1;
        bus.RegDst = r_t ? 2'd1 : 2'd0;
        bus.MemtoReg = lw;
        state_d = FETCH;
        retire = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // reset forces every enable low even while the state register is held
    if (rst) begin
      bus.IRWr = 1'b0;
      bus.PCWr = 1'b0;
      bus.RFWr = 1'b0;
      bus.DMWr = 1'b0;
      bus.DMRd = 1'b0;
      bus.Illegal = 1'b0;
    end
  end
endmodule
